// File: rtl/i2c_pkg.sv
// -----------------------------------------------------------------------------
// i2c_pkg -- shared definitions for the I2C slave.
//   state_t        : protocol FSM states
//   CNT_W          : width of the bit counter
//   ACK / NACK     : SDA levels of the acknowledge bit
//   shift_in_bit   : append a sampled bit to a byte (MSB- or LSB-first)
//   shift_out_bit  : advance a transmit byte by one bit
//   lead_bit       : bit currently presented by a transmit byte
// -----------------------------------------------------------------------------
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_RX,
        ST_RX_ACK,
        ST_TX,
        ST_TX_ACK,
        ST_IGNORE
    } state_t;

    localparam int   CNT_W = 4;
    localparam logic ACK   = 1'b0;
    localparam logic NACK  = 1'b1;

    function automatic logic [7:0] shift_in_bit(input logic [7:0] cur, input logic b,
                                                input bit lsb_first);
        return lsb_first ? {b, cur[7:1]} : {cur[6:0], b};
    endfunction

    function automatic logic [7:0] shift_out_bit(input logic [7:0] cur, input bit lsb_first);
        return lsb_first ? {1'b0, cur[7:1]} : {cur[6:0], 1'b0};
    endfunction

    function automatic logic lead_bit(input logic [7:0] cur, input bit lsb_first);
        return lsb_first ? cur[0] : cur[7];
    endfunction

endpackage

// File: rtl/i2c_sync_filter.sv
// -----------------------------------------------------------------------------
// i2c_sync_filter -- brings one asynchronous bus line into the clk domain.
// Two-flop synchronizer, optional 3-sample majority filter, edge detect.
// Build option: I2C_SLAVE_GLITCH_FILTER_EN enables the majority filter
// (2 clk extra latency); without it the synchronizer output is used directly.
//   clk, rst : system clock, synchronous active-high reset
//   din      : asynchronous line input
//   level    : synchronized (filtered) line level
//   rise     : one-clk pulse when level goes 0->1
//   fall     : one-clk pulse when level goes 1->0
// All flops reset to 1, the idle level of an I2C line, so no edge is
// reported on leaving reset while the bus is idle.
// -----------------------------------------------------------------------------
module i2c_sync_filter (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [1:0] sync_q, sync_d;
    logic       prev_q, prev_d;
    logic       filt;

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    logic [2:0] hist_q, hist_d;

    always_ff @(posedge clk) begin
        if (rst) hist_q <= 3'b111;
        else     hist_q <= hist_d;
    end

    always_comb begin
        hist_d = {hist_q[1:0], sync_q[1]};
    end

    // Majority over three fully registered samples: a single-clk pulse can
    // never win, and a real transition shows up two clks later.
    assign filt = (hist_q[0] & hist_q[1]) | (hist_q[1] & hist_q[2]) | (hist_q[0] & hist_q[2]);
`else
    assign filt = sync_q[1];
`endif

    always_comb begin
        sync_d = {sync_q[0], din};
        prev_d = filt;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours; blocking here would
    // collapse the two synchronizer stages into one.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
            prev_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level = filt;
    assign rise  = filt & ~prev_q;
    assign fall  = ~filt & prev_q;

endmodule

// File: rtl/i2c_slave.sv
// -----------------------------------------------------------------------------
// i2c_slave -- 7-bit addressed I2C slave, byte-level client interface.
// Build option: I2C_SLAVE_GLITCH_FILTER_EN adds a majority glitch filter to
// the sclk and sda_in inputs (see i2c_sync_filter).
// Parameters:
//   SLAVE_ADDR : 7-bit bus address
//   LSB_FIRST  : 1 = bytes shifted LSB first, 0 = MSB first
// Ports:
//   clk, rst : system clock (>= 8x sclk), synchronous active-high reset
//   sclk     : bus clock (async)
//   sda_in   : bus data as sensed (async)
//   sda_oe   : 1 = pull SDA low (open drain, tristate lives above)
//   rx_data  : last byte written by the master; rx_valid pulses on update
//   tx_data  : byte returned on a master read; tx_req pulses for the next one
//   busy     : slave is engaged in an addressed transfer
// -----------------------------------------------------------------------------
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h01,
    parameter bit         LSB_FIRST  = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       busy
);

    logic scl, scl_rise, scl_fall;
    logic sda, sda_rise, sda_fall;

    i2c_sync_filter u_scl (
        .clk   (clk),
        .rst   (rst),
        .din   (sclk),
        .level (scl),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    i2c_sync_filter u_sda (
        .clk   (clk),
        .rst   (rst),
        .din   (sda_in),
        .level (sda),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             rw_q, rw_d;
    logic             sda_oe_q, sda_oe_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             tx_req_q, tx_req_d;

    logic       start_det, stop_det;
    logic [7:0] shift_in;
    logic [7:0] shift_out;

    assign start_det = sda_fall & scl;
    assign stop_det  = sda_rise & scl;
    assign shift_in  = shift_in_bit(shift_q, sda, LSB_FIRST);
    assign shift_out = shift_out_bit(shift_q, LSB_FIRST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            rw_q       <= 1'b0;
            sda_oe_q   <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            rw_q       <= rw_d;
            sda_oe_q   <= sda_oe_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_req_q   <= tx_req_d;
        end
    end

    // Next-state logic. In the ACK states cnt_q marks the phase: 0 until the
    // ninth rising edge, 1 after it, so the two falling edges of the ACK bit
    // (start driving, stop driving) can be told apart.
    always_comb begin
        // NOTE: every signal gets a hold/default value up front so no path
        // through the case below can leave one unassigned and infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        rw_d       = rw_q;
        sda_oe_d   = sda_oe_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_req_d   = 1'b0;

        if (stop_det) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            sda_oe_d = 1'b0;
        end else if (start_det) begin
            state_d  = ST_ADDR;
            cnt_d    = '0;
            shift_d  = '0;
            sda_oe_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_IGNORE: begin
                end
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d = shift_in;
                        cnt_d   = cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(7)) begin
                            cnt_d = '0;
                            rw_d  = shift_in[0];
                            if (shift_in[7:1] == SLAVE_ADDR) begin
                                state_d  = ST_ADDR_ACK;
                                tx_req_d = shift_in[0];
                            end else begin
                                state_d = ST_IGNORE;
                            end
                        end
                    end
                end
                ST_ADDR_ACK, ST_RX_ACK: begin
                    if (scl_fall && cnt_q == '0) begin
                        sda_oe_d = ~ACK;
                    end else if (scl_rise) begin
                        cnt_d = CNT_W'(1);
                    end else if (scl_fall) begin
                        cnt_d = '0;
                        if (state_q == ST_ADDR_ACK && rw_q) begin
                            state_d  = ST_TX;
                            shift_d  = tx_data;
                            sda_oe_d = ~lead_bit(tx_data, LSB_FIRST);
                        end else begin
                            state_d  = ST_RX;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                ST_RX: begin
                    if (scl_rise) begin
                        shift_d = shift_in;
                        cnt_d   = cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(7)) begin
                            cnt_d      = '0;
                            rx_data_d  = shift_in;
                            rx_valid_d = 1'b1;
                            state_d    = ST_RX_ACK;
                        end
                    end
                end
                ST_TX: begin
                    if (scl_rise) begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(7)) begin
                            cnt_d   = '0;
                            state_d = ST_TX_ACK;
                        end
                    end else if (scl_fall) begin
                        shift_d  = shift_out;
                        sda_oe_d = ~lead_bit(shift_out, LSB_FIRST);
                    end
                end
                ST_TX_ACK: begin
                    if (scl_fall && cnt_q == '0) begin
                        sda_oe_d = 1'b0;
                    end else if (scl_rise) begin
                        if (sda == NACK) begin
                            state_d = ST_IGNORE;
                        end else begin
                            cnt_d    = CNT_W'(1);
                            tx_req_d = 1'b1;
                        end
                    end else if (scl_fall) begin
                        cnt_d    = '0;
                        state_d  = ST_TX;
                        shift_d  = tx_data;
                        sda_oe_d = ~lead_bit(tx_data, LSB_FIRST);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Output logic
    always_comb begin
        case (state_q)
            ST_ADDR_ACK, ST_RX, ST_RX_ACK, ST_TX, ST_TX_ACK: busy = 1'b1;
            default:                                         busy = 1'b0;
        endcase
    end

    assign sda_oe   = sda_oe_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign tx_req   = tx_req_q;

endmodule

// File: tb/tb_i2c_slave.sv
// -----------------------------------------------------------------------------
// tb_i2c_slave -- directed bench for i2c_slave (SLAVE_ADDR=7'h01, MSB first).
// A bus-master model drives sclk and an open-drain SDA (sda_in is the
// wired-AND of the master and the slave). A table of whole transactions is
// applied in a loop; restart, glitch and reset-mid-read are hand sequences.
// -----------------------------------------------------------------------------
module tb_i2c_slave;

    localparam int Q = 10;   // clk cycles per quarter sclk period

    logic       clk = 1'b0;
    logic       rst;
    logic       sclk;
    logic       sda_m;
    logic       sda_bus;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_req;
    logic       busy;

    assign sda_bus = sda_m & ~sda_oe;

    i2c_slave #(
        .SLAVE_ADDR (7'h01),
        .LSB_FIRST  (1'b0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sclk     (sclk),
        .sda_in   (sda_bus),
        .sda_oe   (sda_oe),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_req   (tx_req),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Event counters, read as before/after deltas
    int rxv_cnt = 0;
    int txr_cnt = 0;
    int oe_cnt  = 0;
    always @(posedge clk) begin
        if (rx_valid === 1'b1) rxv_cnt <= rxv_cnt + 1;
        if (tx_req === 1'b1)   txr_cnt <= txr_cnt + 1;
        if (sda_oe === 1'b1)   oe_cnt  <= oe_cnt + 1;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One bus bit; returns SDA as sampled mid-high. Optional 1-clk low
    // glitch on sclk during the high phase.
    task automatic bus_bit(input logic b, input logic glitch, output logic r);
        sda_m = b;
        wait_clk(Q);
        sclk = 1'b1;
        wait_clk(Q);
        if (glitch) begin
            sclk = 1'b0;
            @(negedge clk);
            sclk = 1'b1;
        end
        @(negedge clk);
        r = sda_bus;
        wait_clk(Q);
        sclk = 1'b0;
        wait_clk(Q);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1;
        wait_clk(Q);
        sclk = 1'b1;
        wait_clk(Q);
        sda_m = 1'b0;
        wait_clk(Q);
        sclk = 1'b0;
        wait_clk(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0;
        wait_clk(Q);
        sclk = 1'b1;
        wait_clk(Q);
        sda_m = 1'b1;
        wait_clk(Q);
    endtask

    // Sends a byte MSB first; acked = 1 when SDA was low on the 9th bit.
    task automatic send_byte(input logic [7:0] b, input int glitch_bit, output logic acked);
        logic r;
        for (int i = 7; i >= 0; i--) bus_bit(b[i], (i == glitch_bit), r);
        bus_bit(1'b1, 1'b0, r);
        acked = ~r;
    endtask

    // Reads a byte MSB first, then answers with ACK or NACK.
    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, 1'b0, r);
            d[i] = r;
        end
        bus_bit(nack, 1'b0, r);
    endtask

    typedef struct {
        logic [7:0] addr_byte;
        logic [7:0] wdata;
        logic [7:0] tx_byte;
        logic       exp_addr_ack;
        logic       exp_data_ack;
        logic [7:0] exp_rd;
        logic       exp_busy_mid;
        logic [7:0] exp_rx;
        int         exp_rxv;
        int         exp_txr;
        logic       exp_oe;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs [NV];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic       ack;
        logic [7:0] rd;
        logic       r;
        int         rxv0, txr0, oe0;

        // addr, wdata, tx, addr_ack, data_ack, rd, busy_mid, rx_data, rxv, txr, oe
        vecs[0] = '{8'h02, 8'hA5, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 8'hA5, 1, 0, 1'b1};
        vecs[1] = '{8'h03, 8'h00, 8'h3C, 1'b1, 1'b0, 8'h3C, 1'b0, 8'hA5, 0, 1, 1'b1};
        vecs[2] = '{8'h10, 8'h77, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'hA5, 0, 0, 1'b0};
        vecs[3] = '{8'h02, 8'h00, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 8'h00, 1, 0, 1'b1};
        vecs[4] = '{8'h03, 8'h00, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b0, 8'h00, 0, 1, 1'b1};
        vecs[5] = '{8'h11, 8'h00, 8'h5A, 1'b0, 1'b0, 8'hFF, 1'b0, 8'h00, 0, 0, 1'b0};
        vecs[6] = '{8'h02, 8'h81, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 8'h81, 1, 0, 1'b1};

        rst     = 1'b1;
        sclk    = 1'b1;
        sda_m   = 1'b1;
        tx_data = 8'h00;
        wait_clk(4);

        check("rst_sda_oe",   sda_oe,   0);
        check("rst_rx_data",  rx_data,  0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_tx_req",   tx_req,   0);
        check("rst_busy",     busy,     0);

        rst = 1'b0;
        wait_clk(Q);

        for (int i = 0; i < NV; i++) begin
            rxv0    = rxv_cnt;
            txr0    = txr_cnt;
            oe0     = oe_cnt;
            tx_data = vecs[i].tx_byte;

            i2c_start();
            send_byte(vecs[i].addr_byte, -1, ack);
            check($sformatf("v%0d_addr_ack", i), ack, vecs[i].exp_addr_ack);
            check($sformatf("v%0d_busy_addr", i), busy, vecs[i].exp_addr_ack);

            if (vecs[i].addr_byte[0]) begin
                read_byte(1'b1, rd);
                check($sformatf("v%0d_read_byte", i), rd, vecs[i].exp_rd);
            end else begin
                send_byte(vecs[i].wdata, -1, ack);
                check($sformatf("v%0d_data_ack", i), ack, vecs[i].exp_data_ack);
            end
            check($sformatf("v%0d_busy_data", i), busy, vecs[i].exp_busy_mid);

            i2c_stop();
            wait_clk(Q);
            check($sformatf("v%0d_busy_stop", i), busy, 0);
            check($sformatf("v%0d_rx_data", i), rx_data, vecs[i].exp_rx);
            check($sformatf("v%0d_rx_valid_cnt", i), rxv_cnt - rxv0, vecs[i].exp_rxv);
            check($sformatf("v%0d_tx_req_cnt", i), txr_cnt - txr0, vecs[i].exp_txr);
            check($sformatf("v%0d_oe_seen", i), (oe_cnt != oe0), vecs[i].exp_oe);
        end

        // Repeated START after 4 data bits discards the partial byte
        rxv0 = rxv_cnt;
        i2c_start();
        send_byte(8'h02, -1, ack);
        check("rs_addr1_ack", ack, 1);
        bus_bit(1'b1, 1'b0, r);
        bus_bit(1'b0, 1'b0, r);
        bus_bit(1'b1, 1'b0, r);
        bus_bit(1'b1, 1'b0, r);
        i2c_start();
        check("rs_no_partial_valid", rxv_cnt - rxv0, 0);
        send_byte(8'h02, -1, ack);
        check("rs_addr2_ack", ack, 1);
        send_byte(8'h11, -1, ack);
        check("rs_data_ack", ack, 1);
        i2c_stop();
        wait_clk(Q);
        check("rs_rx_valid_cnt", rxv_cnt - rxv0, 1);
        check("rs_rx_data", rx_data, 8'h11);

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
        // 1-clk low glitch on sclk during data bit 3 is filtered out
        rxv0 = rxv_cnt;
        i2c_start();
        send_byte(8'h02, -1, ack);
        check("gl_addr_ack", ack, 1);
        send_byte(8'hB6, 3, ack);
        check("gl_data_ack", ack, 1);
        i2c_stop();
        wait_clk(Q);
        check("gl_rx_valid_cnt", rxv_cnt - rxv0, 1);
        check("gl_rx_data", rx_data, 8'hB6);
`endif

        // Reset in the middle of a read byte
        tx_data = 8'h00;
        i2c_start();
        send_byte(8'h03, -1, ack);
        check("mr_addr_ack", ack, 1);
        bus_bit(1'b1, 1'b0, r);
        check("mr_bit7", r, 0);
        bus_bit(1'b1, 1'b0, r);
        check("mr_bit6", r, 0);
        check("mr_pre_oe", sda_oe, 1);
        rxv0 = rxv_cnt;
        txr0 = txr_cnt;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mr_sda_oe",   sda_oe,   0);
        check("mr_rx_data",  rx_data,  0);
        check("mr_rx_valid", rx_valid, 0);
        check("mr_tx_req",   tx_req,   0);
        check("mr_busy",     busy,     0);
        wait_clk(3);
        rst = 1'b0;
        wait_clk(Q);
        i2c_stop();
        wait_clk(Q);
        check("mr_no_rx_valid", rxv_cnt - rxv0, 0);
        check("mr_no_tx_req",   txr_cnt - txr0, 0);
        check("mr_busy_after",  busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
